// File: rtl/dcache_dm_wt_pkg.sv
// Shared types, field widths and address-split helpers for the
// direct-mapped write-through data cache.
package dcache_dm_wt_pkg;

  localparam int ADDR_BITS   = 16;
  localparam int DATA_BITS   = 16;
  localparam int INDEX_BITS  = 4;
  localparam int OFFSET_BITS = 2;
  localparam int TAG_BITS    = ADDR_BITS - 1 - OFFSET_BITS - INDEX_BITS;
  localparam int LINES       = 2 ** INDEX_BITS;
  localparam int WORDS       = 2 ** OFFSET_BITS;

  typedef logic [ADDR_BITS-1:0]   addr_t;
  typedef logic [DATA_BITS-1:0]   word_t;
  typedef logic [TAG_BITS-1:0]    tag_t;
  typedef logic [INDEX_BITS-1:0]  index_t;
  typedef logic [OFFSET_BITS-1:0] offset_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  localparam offset_t FILL_LAST = {OFFSET_BITS{1'b1}};
  localparam offset_t FILL_ONE  = offset_t'(1'b1);

  function automatic offset_t offset_of(addr_t a);
    return a[OFFSET_BITS:1];
  endfunction

  function automatic index_t index_of(addr_t a);
    return a[OFFSET_BITS+INDEX_BITS:OFFSET_BITS+1];
  endfunction

  function automatic tag_t tag_of(addr_t a);
    return a[ADDR_BITS-1:OFFSET_BITS+INDEX_BITS+1];
  endfunction

endpackage

// File: rtl/dcache_dm_wt_if.sv
// CPU-side and memory-side bus of the data cache; master is the
// environment (CPU plus word memory), slave is the cache.
interface dcache_dm_wt_if;
  import dcache_dm_wt_pkg::*;

  logic  cpu_req;
  logic  cpu_wr;
  addr_t cpu_addr;
  word_t cpu_wdata;
  word_t cpu_rdata;
  logic  cpu_ready;
  addr_t mem_addr;
  word_t mem_wdata;
  logic  mem_enable;
  logic  mem_wr;
  word_t mem_rdata;

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_enable, mem_wr
  );

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_enable, mem_wr
  );

endinterface

// File: rtl/dcache_dm_wt_array.sv
// Flop-based data, tag and valid storage with a combinational read port,
// a word write port and a tag/valid write port.
module dcache_dm_wt_array
  import dcache_dm_wt_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  index_t  rd_index,
  input  offset_t rd_offset,
  output word_t   rd_word,
  output tag_t    rd_tag,
  output logic    rd_valid,
  input  logic    word_we,
  input  index_t  word_index,
  input  offset_t word_offset,
  input  word_t   word_data,
  input  logic    tv_we,
  input  logic    tv_clr,
  input  index_t  tv_index,
  input  tag_t    tv_tag
);

  word_t            data_r [LINES][WORDS];
  tag_t             tag_r  [LINES];
  logic [LINES-1:0] valid_r;

  assign rd_word  = data_r[rd_index][rd_offset];
  assign rd_tag   = tag_r[rd_index];
  assign rd_valid = valid_r[rd_index];

  // Data words: written by CPU write hits and by line fills.
  always_ff @(posedge clk) begin
    if (word_we) begin
      data_r[word_index][word_offset] <= word_data;
    end
  end

  // Tags carry no reset; they are only meaningful under a set valid bit.
  always_ff @(posedge clk) begin
    if (tv_we) begin
      tag_r[tv_index] <= tv_tag;
    end
  end

  // Valid bits: cleared when a fill starts, set when it completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {LINES{1'b0}};
    end else if (tv_clr) begin
      valid_r[tv_index] <= 1'b0;
    end else if (tv_we) begin
      valid_r[tv_index] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache: same-cycle
// read hits and writes, 4-cycle line fill on a read miss.
module dcache_dm_wt
  import dcache_dm_wt_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  dcache_dm_wt_if.slave  bus
);

  state_e  state_r;
  offset_t fill_cnt_r;
  index_t  fill_index_r;
  tag_t    fill_tag_r;

  tag_t    req_tag_s;
  index_t  req_index_s;
  offset_t req_offset_s;
  word_t   rd_word_s;
  tag_t    rd_tag_s;
  logic    rd_valid_s;
  logic    hit_s;
  logic    miss_s;
  logic    word_we_s;
  index_t  word_index_s;
  offset_t word_offset_s;
  word_t   word_data_s;
  logic    tv_we_s;
  logic    tv_clr_s;
  index_t  tv_index_s;
  tag_t    tv_tag_s;

  assign req_tag_s    = tag_of(bus.cpu_addr);
  assign req_index_s  = index_of(bus.cpu_addr);
  assign req_offset_s = offset_of(bus.cpu_addr);
  assign hit_s        = rd_valid_s & (rd_tag_s == req_tag_s);

  dcache_dm_wt_array u_array (
    .clk         (clk),
    .rst         (rst),
    .rd_index    (req_index_s),
    .rd_offset   (req_offset_s),
    .rd_word     (rd_word_s),
    .rd_tag      (rd_tag_s),
    .rd_valid    (rd_valid_s),
    .word_we     (word_we_s),
    .word_index  (word_index_s),
    .word_offset (word_offset_s),
    .word_data   (word_data_s),
    .tv_we       (tv_we_s),
    .tv_clr      (tv_clr_s),
    .tv_index    (tv_index_s),
    .tv_tag      (tv_tag_s)
  );

  // Output and array-port muxing; reset forces every strobe low so the
  // memory is left alone while it loads its image.
  always_comb begin
    bus.cpu_ready  = 1'b0;
    bus.cpu_rdata  = 16'h0000;
    bus.mem_addr   = 16'h0000;
    bus.mem_wdata  = 16'h0000;
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    miss_s         = 1'b0;
    word_we_s      = 1'b0;
    word_index_s   = {INDEX_BITS{1'b0}};
    word_offset_s  = {OFFSET_BITS{1'b0}};
    word_data_s    = 16'h0000;
    tv_we_s        = 1'b0;
    tv_clr_s       = 1'b0;
    tv_index_s     = {INDEX_BITS{1'b0}};
    tv_tag_s       = {TAG_BITS{1'b0}};
    if (!rst) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.cpu_req && bus.cpu_wr) begin
            bus.mem_enable = 1'b1;
            bus.mem_wr     = 1'b1;
            bus.mem_addr   = {bus.cpu_addr[ADDR_BITS-1:1], 1'b0};
            bus.mem_wdata  = bus.cpu_wdata;
            bus.cpu_ready  = 1'b1;
            word_we_s      = hit_s;
            word_index_s   = req_index_s;
            word_offset_s  = req_offset_s;
            word_data_s    = bus.cpu_wdata;
          end else if (bus.cpu_req && hit_s) begin
            bus.cpu_ready  = 1'b1;
            bus.cpu_rdata  = rd_word_s;
          end else if (bus.cpu_req) begin
            miss_s         = 1'b1;
            tv_clr_s       = 1'b1;
            tv_index_s     = req_index_s;
          end else begin
            miss_s         = 1'b0;
          end
        end
        ST_FILL: begin
          bus.mem_enable = 1'b1;
          bus.mem_addr   = {fill_tag_r, fill_index_r, fill_cnt_r, 1'b0};
          word_we_s      = 1'b1;
          word_index_s   = fill_index_r;
          word_offset_s  = fill_cnt_r;
          word_data_s    = bus.mem_rdata;
          if (fill_cnt_r == FILL_LAST) begin
            tv_we_s      = 1'b1;
            tv_index_s   = fill_index_r;
            tv_tag_s     = fill_tag_r;
          end else begin
            tv_we_s      = 1'b0;
          end
        end
        default: begin
          miss_s = 1'b0;
        end
      endcase
    end else begin
      miss_s = 1'b0;
    end
  end

  // Fill FSM; the missing line's tag/index are latched so the fill
  // completes even if the CPU drops its request part-way through.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      fill_cnt_r   <= {OFFSET_BITS{1'b0}};
      fill_index_r <= {INDEX_BITS{1'b0}};
      fill_tag_r   <= {TAG_BITS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (miss_s) begin
            state_r      <= ST_FILL;
            fill_cnt_r   <= {OFFSET_BITS{1'b0}};
            fill_index_r <= req_index_s;
            fill_tag_r   <= req_tag_s;
          end
        end
        ST_FILL: begin
          fill_cnt_r <= fill_cnt_r + FILL_ONE;
          if (fill_cnt_r == FILL_LAST) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_dm_wt.sv
// Scoreboard bench for dcache_dm_wt: the driver queues expected CPU returns
// and memory transactions, a negedge monitor pops and compares them.
module tb_dcache_dm_wt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_load = 1'b1;

  dcache_dm_wt_if bus ();

  dcache_dm_wt dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem_arr [0:1023];
  logic [15:0] exp_resp [$];
  logic [15:0] exp_mrd  [$];
  logic [31:0] exp_mwr  [$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [15:0] mem_init(int i);
    logic [15:0] v;
    v = 16'hA000 + i[15:0];
    if (i == 8) v = 16'h1234;
    return v;
  endfunction

  // Single-cycle word memory: combinational read, write at the edge.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= mem_init(i);
    end else if (bus.mem_enable && bus.mem_wr) begin
      mem_arr[bus.mem_addr[10:1]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem_arr[bus.mem_addr[10:1]];

  // Monitor: compare every DUT-presented transaction against the queues.
  always @(negedge clk) begin
    logic [15:0] e16;
    logic [31:0] e32;
    if (rst) begin
      n_cmp++;
      if (bus.mem_enable !== 1'b0 || bus.mem_wr !== 1'b0 || bus.cpu_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_quiet: got en=%b wr=%b ready=%b required all 0",
                 bus.mem_enable, bus.mem_wr, bus.cpu_ready);
      end
    end else begin
      if (bus.cpu_ready === 1'b1) begin
        n_cmp++;
        if (exp_resp.size() == 0) begin
          n_bad++;
          $display("FAIL cpu_resp: got unexpected ready rdata=%h required none", bus.cpu_rdata);
        end else begin
          e16 = exp_resp.pop_front();
          if (bus.cpu_rdata !== e16) begin
            n_bad++;
            $display("FAIL cpu_rdata: got %h required %h", bus.cpu_rdata, e16);
          end
        end
      end
      if (bus.mem_enable === 1'b1 && bus.mem_wr === 1'b0) begin
        n_cmp++;
        if (exp_mrd.size() == 0) begin
          n_bad++;
          $display("FAIL mem_read: got unexpected read addr=%h required none", bus.mem_addr);
        end else begin
          e16 = exp_mrd.pop_front();
          if (bus.mem_addr !== e16) begin
            n_bad++;
            $display("FAIL mem_read_addr: got %h required %h", bus.mem_addr, e16);
          end
        end
      end
      if (bus.mem_enable === 1'b1 && bus.mem_wr === 1'b1) begin
        n_cmp++;
        if (exp_mwr.size() == 0) begin
          n_bad++;
          $display("FAIL mem_write: got unexpected write %h<=%h required none",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          e32 = exp_mwr.pop_front();
          if ({bus.mem_addr, bus.mem_wdata} !== e32) begin
            n_bad++;
            $display("FAIL mem_write: got %h<=%h required %h<=%h",
                     bus.mem_addr, bus.mem_wdata, e32[31:16], e32[15:0]);
          end
        end
      end
    end
  end

  task automatic push_fill(input logic [15:0] addr);
    logic [15:0] base;
    base = addr & 16'hFFF8;
    for (int k = 0; k < 4; k++) exp_mrd.push_back(base + 16'(2 * k));
  endtask

  task automatic idle_check();
    @(negedge clk);
    n_cmp++;
    if (bus.mem_enable !== 1'b0 || bus.cpu_ready !== 1'b0 || bus.cpu_rdata !== 16'h0000) begin
      n_bad++;
      $display("FAIL idle_quiet: got en=%b ready=%b rdata=%h required 0 0 0000",
               bus.mem_enable, bus.cpu_ready, bus.cpu_rdata);
    end
  endtask

  task automatic do_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] exp_rd, input int exp_lat);
    int lat;
    idle_check();
    if (wr) exp_mwr.push_back({addr & 16'hFFFE, wdata});
    exp_resp.push_back(wr ? 16'h0000 : exp_rd);
    if (exp_lat > 1) push_fill(addr);
    @(posedge clk); #1;
    bus.cpu_req   = 1'b1;
    bus.cpu_wr    = wr;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.cpu_ready !== 1'b1 && lat < 20);
    n_cmp++;
    if (lat != exp_lat) begin
      n_bad++;
      $display("FAIL latency %h: got %0d cycles required %0d", addr, lat, exp_lat);
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    bus.cpu_wr  = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    mem_load = 1'b0;

    do_access(1'b0, 16'h0010, 16'h0000, 16'h1234, 6);   // cold miss, fill
    do_access(1'b0, 16'h0014, 16'h0000, 16'hA00A, 1);   // hit, no memory access
    do_access(1'b1, 16'h0012, 16'hBEEF, 16'h0000, 1);   // write hit
    do_access(1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1);   // cached copy updated
    do_access(1'b1, 16'h0400, 16'h5555, 16'h0000, 1);   // write miss, no allocate
    do_access(1'b0, 16'h0400, 16'h0000, 16'h5555, 6);   // still a miss
    do_access(1'b0, 16'h0010, 16'h0000, 16'h1234, 1);
    do_access(1'b0, 16'h0090, 16'h0000, 16'hA048, 6);   // same index, new tag
    do_access(1'b0, 16'h0010, 16'h0000, 16'h1234, 6);   // evicted
    check_val("mem_word9", mem_arr[9], 16'hBEEF);
    check_val("mem_word512", mem_arr[512], 16'h5555);

    // Request dropped mid-fill: the fill still completes and the line is valid.
    idle_check();
    push_fill(16'h0300);
    @(posedge clk); #1;
    bus.cpu_req  = 1'b1;
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = 16'h0300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    do_access(1'b0, 16'h0300, 16'h0000, 16'hA180, 1);

    // Reset in the second fill cycle aborts the fill; the line stays invalid.
    idle_check();
    exp_mrd.push_back(16'h0200);
    @(posedge clk); #1;
    bus.cpu_req  = 1'b1;
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = 16'h0200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst         = 1'b0;
    bus.cpu_req = 1'b0;
    do_access(1'b0, 16'h0200, 16'h0000, 16'hA100, 6);
    do_access(1'b0, 16'h0014, 16'h0000, 16'hA00A, 6);  // reset cleared all lines

    idle_check();
    check_val("resp_queue_left", 16'(exp_resp.size()), 16'h0000);
    check_val("mrd_queue_left", 16'(exp_mrd.size()), 16'h0000);
    check_val("mwr_queue_left", 16'(exp_mwr.size()), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
